// File: rtl/seq_array_multiplier.sv
// seq_array_multiplier: iterative shift-and-add multiplier with an optional
// multiply-accumulate step and valid/ready handshakes on both sides.
// One multiplier bit is retired per cycle, so an operation takes WIDTH cycles.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only while idle)
//   a, b                  WIDTH-bit multiplicand / multiplier
//   signed_mode           1 = two's complement operands and product
//   accumulate            1 = add product into acc on completion
//   clear_acc             1 = acc and overflow restart from 0 for this op
//   out_valid / out_ready result handshake (out_valid high only when done)
//   product               2*WIDTH-bit result of the last completed multiply
//   acc                   ACC_WIDTH-bit running accumulator (wraps)
//   overflow              sticky accumulator overflow flag
module seq_array_multiplier #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 2 * WIDTH + 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    input  logic                 accumulate,
    input  logic                 clear_acc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 overflow
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      mcand_q, mcand_d;
    logic [PW-1:0]         pp_q, pp_d;       // {partial sum, remaining multiplier bits}
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  neg_q, neg_d;
    logic                  signed_q, signed_d;
    logic                  accum_q, accum_d;
    logic                  clear_q, clear_d;
    logic [PW-1:0]         product_q, product_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                  ovf_q, ovf_d;

    // Operand magnitudes; |-2^(WIDTH-1)| still fits as an unsigned WIDTH-bit value
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_mag = (signed_mode && a[WIDTH-1]) ? WIDTH'(0 - a) : a;
    assign b_mag = (signed_mode && b[WIDTH-1]) ? WIDTH'(0 - b) : b;

    // One iteration: conditional add into the upper half, then shift right
    logic [WIDTH:0]  upper_sum;
    logic [PW-1:0]   pp_shift;
    assign upper_sum = {1'b0, pp_q[PW-1:WIDTH]} + (pp_q[0] ? {1'b0, mcand_q} : '0);
    assign pp_shift  = {upper_sum, pp_q[WIDTH-1:1]};

    // Final signed/unsigned product taken from the last iteration's result
    logic [PW-1:0]        prod_final;
    logic signed [PW-1:0] prod_s;
    assign prod_final = neg_q ? PW'(0 - pp_shift) : pp_shift;
    assign prod_s     = prod_final;

    // Accumulator add with mode-dependent extension and overflow detection
    logic [ACC_WIDTH-1:0] prod_ext, acc_base;
    logic [ACC_WIDTH:0]   sum_full;
    logic                 add_ovf;
    assign prod_ext = signed_q ? ACC_WIDTH'(prod_s) : ACC_WIDTH'(prod_final);
    assign acc_base = clear_q ? '0 : acc_q;
    assign sum_full = {1'b0, acc_base} + {1'b0, prod_ext};
    assign add_ovf  = signed_q
                    ? ((acc_base[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                       (sum_full[ACC_WIDTH-1] != acc_base[ACC_WIDTH-1]))
                    : sum_full[ACC_WIDTH];

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            pp_q      <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            signed_q  <= 1'b0;
            accum_q   <= 1'b0;
            clear_q   <= 1'b0;
            product_q <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            pp_q      <= pp_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            signed_q  <= signed_d;
            accum_q   <= accum_d;
            clear_q   <= clear_d;
            product_q <= product_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        pp_d      = pp_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        signed_d  = signed_q;
        accum_d   = accum_q;
        clear_d   = clear_q;
        product_d = product_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = a_mag;
                    pp_d     = {{WIDTH{1'b0}}, b_mag};
                    neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    signed_d = signed_mode;
                    accum_d  = accumulate;
                    clear_d  = clear_acc;
                    cnt_d    = '0;
                    state_d  = MUL;
                end
            end
            MUL: begin
                pp_d  = pp_shift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d   = DONE;
                    product_d = prod_final;
                    if (accum_q) begin
                        acc_d = sum_full[ACC_WIDTH-1:0];
                        ovf_d = (ovf_q & ~clear_q) | add_ovf;
                    end else if (clear_q) begin
                        acc_d = '0;
                        ovf_d = 1'b0;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = product_q;
    assign acc       = acc_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Directed bench for seq_array_multiplier at WIDTH=4, ACC_WIDTH=8.
module tb_seq_array_multiplier;

    localparam int unsigned W  = 4;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          signed_mode;
    logic          accumulate;
    logic          clear_acc;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] product;
    logic [AW-1:0] acc;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    seq_array_multiplier #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .accumulate  (accumulate),
        .clear_acc   (clear_acc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product),
        .acc         (acc),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for out_valid; checks latency.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sm, input logic ac, input logic cl,
                          input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        a = av; b = bv; signed_mode = sm; accumulate = ac; clear_acc = cl;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom);
        signed_mode = ~sm; accumulate = ~ac; clear_acc = ~cl;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(W));
    endtask

    task automatic check_res(input string tag, input logic [2*W-1:0] ep,
                             input logic [AW-1:0] ea, input logic eo);
        chk({tag, "_product"}, 32'(product), 32'(ep));
        chk({tag, "_acc"}, 32'(acc), 32'(ea));
        chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
    endtask

    // Complete the output handshake and confirm the block is idle again.
    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_outv_low"}, 32'(out_valid), 32'd0);
        chk({tag, "_inrdy_high"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [2*W-1:0] held;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; signed_mode = 1'b0; accumulate = 1'b0; clear_acc = 1'b0;
        #12;
        chk("rst_outv", 32'(out_valid), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_inrdy", 32'(in_ready), 32'd1);

        // Unsigned multiply: 13*11 = 143
        run_op(4'd13, 4'd11, 1'b0, 1'b0, 1'b0, "u13x11");
        check_res("u13x11", 8'h8F, 8'h00, 1'b0);
        finish_op("u13x11");

        // Signed corners
        run_op(4'h8, 4'h8, 1'b1, 1'b0, 1'b0, "sm8xm8");
        check_res("sm8xm8", 8'h40, 8'h00, 1'b0);
        finish_op("sm8xm8");
        run_op(4'hD, 4'h5, 1'b1, 1'b0, 1'b0, "sm3x5");
        check_res("sm3x5", 8'hF1, 8'h00, 1'b0);
        finish_op("sm3x5");
        run_op(4'h7, 4'hF, 1'b1, 1'b0, 1'b0, "s7xm1");
        check_res("s7xm1", 8'hF9, 8'h00, 1'b0);
        finish_op("s7xm1");

        // Accumulate chain: 12, 42, 28
        run_op(4'd3, 4'd4, 1'b0, 1'b1, 1'b1, "acc3x4");
        check_res("acc3x4", 8'h0C, 8'd12, 1'b0);
        finish_op("acc3x4");
        run_op(4'd5, 4'd6, 1'b0, 1'b1, 1'b0, "acc5x6");
        check_res("acc5x6", 8'h1E, 8'd42, 1'b0);
        finish_op("acc5x6");
        run_op(4'hE, 4'd7, 1'b1, 1'b1, 1'b0, "accm2x7");
        check_res("accm2x7", 8'hF2, 8'd28, 1'b0);
        finish_op("accm2x7");

        // Unsigned overflow then clear
        run_op(4'd15, 4'd15, 1'b0, 1'b1, 1'b1, "ovf1");
        check_res("ovf1", 8'hE1, 8'd225, 1'b0);
        finish_op("ovf1");
        run_op(4'd15, 4'd15, 1'b0, 1'b1, 1'b0, "ovf2");
        check_res("ovf2", 8'hE1, 8'd194, 1'b1);
        finish_op("ovf2");
        run_op(4'd2, 4'd2, 1'b0, 1'b1, 1'b1, "clr2x2");
        check_res("clr2x2", 8'h04, 8'd4, 1'b0);
        finish_op("clr2x2");

        // Backpressure: 6*7 held for 10 cycles with stray in_valid pulses
        out_ready = 1'b0;
        run_op(4'd6, 4'd7, 1'b0, 1'b0, 1'b0, "bp");
        check_res("bp", 8'h2A, 8'd4, 1'b0);
        held = product;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = 4'd15; b = 4'd15; accumulate = 1'b1; clear_acc = 1'b1;
            @(posedge clk); #1;
            chk("bp_outv", 32'(out_valid), 32'd1);
            chk("bp_inrdy", 32'(in_ready), 32'd0);
            chk("bp_product", 32'(product), 32'(held));
            chk("bp_acc", 32'(acc), 32'd4);
        end
        in_valid = 1'b0;
        finish_op("bp");

        // Reset two cycles into MUL
        a = 4'd13; b = 4'd11; signed_mode = 1'b0; accumulate = 1'b1; clear_acc = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_outv", 32'(out_valid), 32'd0);
        chk("mrst_product", 32'(product), 32'd0);
        chk("mrst_acc", 32'(acc), 32'd0);
        chk("mrst_ovf", 32'(overflow), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(4'd9, 4'd9, 1'b0, 1'b0, 1'b0, "post9x9");
        check_res("post9x9", 8'h51, 8'd0, 1'b0);
        finish_op("post9x9");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
